// File: rtl/dbg_pkg.sv
// Shared types and framing constants for the debug dump reader.
package dbg_pkg;

    // Walk order: header, every register, every memory word, trailer.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RFETCH,
        RSEND,
        MFETCH,
        MSEND,
        TRL
    } dump_state_t;

    localparam logic [7:0] DUMP_HDR = 8'hA5;
    localparam logic [7:0] DUMP_TRL = 8'h5A;

endpackage

// File: rtl/dump_shifter.sv
// Load/shift register for one dumped word plus its byte counter.
// Register words are N bits wide; memory words load zero-extended.
module dump_shifter #(
    parameter int N = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          load_mem,
    input  logic [N-1:0]  reg_word,
    input  logic [31:0]   mem_word,
    input  logic          shift,
    output logic [7:0]    low_byte,
    output logic          last_byte
);

    // Wide enough to hold either a register or a memory word.
    localparam int W  = (N > 32) ? N : 32;
    localparam int NB = W / 8;
    localparam int CW = $clog2(NB) + 1;
    localparam logic [CW-1:0] REG_LAST = CW'(N / 8 - 1);
    localparam logic [CW-1:0] MEM_LAST = CW'(3);

    logic [W-1:0]  sr_reg, sr_next, shifted;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          mem_reg, mem_next;

    // Byte lanes move down by one on every shift; the top lane fills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            if (gi == NB - 1) begin : g_top
                assign shifted[gi*8 +: 8] = 8'h00;
            end else begin : g_mid
                assign shifted[gi*8 +: 8] = sr_reg[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    // Word/counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
            mem_reg <= 1'b0;
        end else begin
            sr_reg  <= sr_next;
            cnt_reg <= cnt_next;
            mem_reg <= mem_next;
        end
    end

    // Load restarts the byte count; each accepted byte shifts and counts.
    always_comb begin
        sr_next  = sr_reg;
        cnt_next = cnt_reg;
        mem_next = mem_reg;
        if (load) begin
            sr_next  = load_mem ? W'(mem_word) : W'(reg_word);
            cnt_next = '0;
            mem_next = load_mem;
        end else if (shift) begin
            sr_next  = shifted;
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign low_byte  = sr_reg[7:0];
    assign last_byte = (cnt_reg == (mem_reg ? MEM_LAST : REG_LAST));

endmodule

// File: rtl/debug_dump.sv
// Walks the core's registers and a memory window through the check ports
// and streams them as a framed, little-endian byte sequence.
module debug_dump
    import dbg_pkg::*;
#(
    parameter int N      = 64,
    parameter int NREG   = 32,
    parameter int MCOUNT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [4:0]    checkra,
    input  logic [N-1:0]  checkr,
    output logic [7:0]    checkma,
    input  logic [31:0]   checkm,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [4:0] RA_LAST = 5'(NREG - 1);
    localparam logic [7:0] MA_LAST = 8'(MCOUNT - 1);

    dump_state_t state_reg, state_next;
    logic [4:0]  ra_reg, ra_next;
    logic [7:0]  ma_reg, ma_next;
    logic        done_reg, done_next;
    logic        accept;
    logic        sh_load, sh_load_mem, sh_shift;
    logic [7:0]  low_byte;
    logic        last_byte;

    dump_shifter #(.N(N)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_mem  (sh_load_mem),
        .reg_word  (checkr),
        .mem_word  (checkm),
        .shift     (sh_shift),
        .low_byte  (low_byte),
        .last_byte (last_byte)
    );

    assign accept = dout_valid && dout_ready;

    // State, index/address registers and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            ma_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ra_reg    <= ra_next;
            ma_reg    <= ma_next;
            done_reg  <= done_next;
        end
    end

    // Next state, index stepping on FETCH entry, and the byte-stream outputs.
    always_comb begin
        state_next  = state_reg;
        ra_next     = ra_reg;
        ma_next     = ma_reg;
        done_next   = 1'b0;
        sh_load     = 1'b0;
        sh_load_mem = 1'b0;
        sh_shift    = 1'b0;
        dout        = 8'h00;
        dout_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                    ra_next    = '0;
                    ma_next    = '0;
                end
            end
            HDR: begin
                dout       = DUMP_HDR;
                dout_valid = 1'b1;
                if (accept) begin
                    state_next = RFETCH;
                    ra_next    = '0;
                end
            end
            RFETCH: begin
                sh_load    = 1'b1;
                state_next = RSEND;
            end
            RSEND: begin
                dout       = low_byte;
                dout_valid = 1'b1;
                if (accept) begin
                    sh_shift = 1'b1;
                    if (last_byte) begin
                        if (ra_reg == RA_LAST) begin
                            state_next = MFETCH;
                            ma_next    = '0;
                        end else begin
                            state_next = RFETCH;
                            ra_next    = ra_reg + 5'd1;
                        end
                    end
                end
            end
            MFETCH: begin
                sh_load     = 1'b1;
                sh_load_mem = 1'b1;
                state_next  = MSEND;
            end
            MSEND: begin
                dout       = low_byte;
                dout_valid = 1'b1;
                if (accept) begin
                    sh_shift = 1'b1;
                    if (last_byte) begin
                        if (ma_reg == MA_LAST) begin
                            state_next = TRL;
                        end else begin
                            state_next = MFETCH;
                            ma_next    = ma_reg + 8'd1;
                        end
                    end
                end
            end
            TRL: begin
                dout       = DUMP_TRL;
                dout_valid = 1'b1;
                if (accept) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign checkra = ra_reg;
    assign checkma = ma_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;

endmodule

// File: tb/tb_debug_dump.sv
// Bench for debug_dump: randomized sink backpressure against a frame model
// built directly from the byte layout of a dump.
module tb_debug_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sel;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default geometry
    logic        a_start, a_ready, a_valid, a_busy, a_done;
    logic [4:0]  a_ra;
    logic [63:0] a_r;
    logic [7:0]  a_ma, a_dout;
    logic [31:0] a_m;

    // Instance B: one register, one memory word
    logic        b_start, b_ready, b_valid, b_busy, b_done;
    logic [4:0]  b_ra;
    logic [63:0] b_r;
    logic [7:0]  b_ma, b_dout;
    logic [31:0] b_m;

    always_comb a_r = 64'h0123456789ABCDEF + 64'(a_ra);
    always_comb a_m = 32'hC0DE0000 | 32'(a_ma);
    always_comb b_r = 64'h0123456789ABCDEF + 64'(b_ra);
    always_comb b_m = 32'hC0DE0000 | 32'(b_ma);

    debug_dump #(.N(64), .NREG(32), .MCOUNT(64)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .checkra(a_ra), .checkr(a_r), .checkma(a_ma), .checkm(a_m),
        .dout(a_dout), .dout_valid(a_valid), .dout_ready(a_ready),
        .busy(a_busy), .done(a_done)
    );

    debug_dump #(.N(64), .NREG(1), .MCOUNT(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .checkra(b_ra), .checkr(b_r), .checkma(b_ma), .checkm(b_m),
        .dout(b_dout), .dout_valid(b_valid), .dout_ready(b_ready),
        .busy(b_busy), .done(b_done)
    );

    logic [7:0] m_dout;
    logic       m_valid, m_busy, m_done;
    always_comb begin
        m_dout  = sel ? b_dout  : a_dout;
        m_valid = sel ? b_valid : a_valid;
        m_busy  = sel ? b_busy  : a_busy;
        m_done  = sel ? b_done  : a_done;
    end

    logic a_ma_hi    = 1'b0;
    logic b_ma_moved = 1'b0;
    always @(negedge clk) begin
        if (a_ma > 8'd63) a_ma_hi <= 1'b1;
        if (b_ma != 8'd0) b_ma_moved <= 1'b1;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected frame: header, registers LSB first, memory words LSB first, trailer.
    task automatic build_exp(input int nreg, input int mcount);
        logic [63:0] v;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < nreg; i++) begin
            v = 64'h0123456789ABCDEF + 64'(i);
            for (int b = 0; b < 8; b++) exp_q.push_back(v[b*8 +: 8]);
        end
        for (int a = 0; a < mcount; a++) begin
            w = 32'hC0DE0000 | 32'(a);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
        end
        exp_q.push_back(8'h5A);
    endtask

    // Called at a negedge with the selected DUT idle; ends one cycle later in HDR.
    task automatic start_dump();
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        check("hdr_busy", 64'(m_busy), 64'd1);
        check("hdr_valid", 64'(m_valid), 64'd1);
        check("hdr_dout", 64'(m_dout), 64'hA5);
    endtask

    // Sink: one sample per negedge, random ready, stall stability checks.
    task automatic collect(input int ready_pct, input int pulse_at, input int abort_at,
                           input int budget, output int first_v, output int done_at,
                           output bit aborted);
        logic [7:0] prev_d;
        bit prev_stall;
        bit pulsed;
        bit rdy;
        prev_d = 8'h00;
        prev_stall = 1'b0;
        pulsed = 1'b0;
        got_q.delete();
        first_v = cyc;
        done_at = -1;
        aborted = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_dout", 64'(m_dout), 64'(prev_d));
            end
            if (m_done) begin
                done_at = cyc;
                break;
            end
            if (abort_at > 0 && got_q.size() == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_outs", 64'({a_valid, a_busy, a_done, a_dout, a_ra, a_ma}), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (pulse_at > 0) begin
                if (!pulsed && got_q.size() == pulse_at) begin
                    if (sel) b_start = 1'b1; else a_start = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    a_start = 1'b0;
                    b_start = 1'b0;
                end
            end
            rdy = (int'($urandom_range(99)) < ready_pct);
            a_ready = rdy;
            b_ready = rdy;
            if (m_valid && rdy) got_q.push_back(m_dout);
            prev_stall = m_valid && !rdy;
            prev_d = m_dout;
            @(negedge clk);
        end
        if (done_at < 0 && !aborted) check("timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check($sformatf("%s_len", tag), 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    int fv, da;
    bit ab;

    initial begin
        sel = 1'b0;
        reset = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", 64'({a_valid, a_busy, a_done, a_dout, a_ra, a_ma}), 64'd0);
        check("rst_b", 64'({b_valid, b_busy, b_done, b_dout, b_ra, b_ma}), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle", 64'({a_valid, a_busy, a_done, a_ra, a_ma}), 64'd0);
        end

        // Full-speed default frame, latency and done pulse width
        build_exp(32, 64);
        start_dump();
        collect(100, 0, 0, 2000, fv, da, ab);
        compare_stream("fast");
        check("fast_latency", 64'(da - fv), 64'd610);
        check("done_busy_low", 64'(m_busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(m_done), 64'd0);
        $display("frame fast: bytes=%0d latency=%0d", got_q.size(), da - fv);

        // 30% ready backpressure
        start_dump();
        collect(30, 0, 0, 8000, fv, da, ab);
        compare_stream("slow");
        $display("frame slow: bytes=%0d cycles=%0d", got_q.size(), da - fv);

        // start re-pulsed during register phase is ignored
        start_dump();
        collect(100, 20, 0, 2000, fv, da, ab);
        compare_stream("repulse");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_restart", 64'({m_busy, m_valid}), 64'd0);
        end
        $display("frame repulse: bytes=%0d", got_q.size());

        // start held high: two back-to-back frames
        a_start = 1'b1;
        @(negedge clk);
        check("held_hdr1", 64'({m_valid, m_dout}), 64'h1A5);
        collect(100, 0, 0, 2000, fv, da, ab);
        compare_stream("held1");
        check("held_done_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        a_start = 1'b0;
        check("held_hdr2", 64'({m_busy, m_valid, m_dout}), 64'h3A5);
        collect(100, 0, 0, 2000, fv, da, ab);
        compare_stream("held2");
        check("held2_latency", 64'(da - fv), 64'd610);
        $display("frames held: second bytes=%0d", got_q.size());

        // Reset mid-dump at byte 100, then a fresh frame
        @(negedge clk);
        start_dump();
        collect(100, 0, 100, 2000, fv, da, ab);
        check("abort_hit", 64'(ab), 64'd1);
        check("abort_bytes", 64'(got_q.size()), 64'd100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_abort_idle", 64'({a_valid, a_busy, a_done, a_dout, a_ra, a_ma}), 64'd0);
        start_dump();
        collect(60, 0, 0, 4000, fv, da, ab);
        compare_stream("fresh");
        $display("frame after reset: bytes=%0d", got_q.size());

        // Minimal geometry instance
        @(negedge clk);
        sel = 1'b1;
        build_exp(1, 1);
        start_dump();
        collect(100, 0, 0, 200, fv, da, ab);
        compare_stream("tiny");
        check("tiny_latency", 64'(da - fv), 64'd16);
        @(negedge clk);
        start_dump();
        collect(40, 0, 0, 400, fv, da, ab);
        compare_stream("tiny_slow");
        $display("frame tiny: bytes=%0d", got_q.size());

        @(negedge clk);
        check("tiny_ma_fixed", 64'(b_ma_moved), 64'd0);
        check("ma_in_range", 64'(a_ma_hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
